// File: rtl/ibex_csr_rmw_ctrl.sv
// Read-modify-write access initiator for a bank of shadowed CSR primitives.
// Runs READ/WRITE/SET/CLEAR over a valid/ready handshake and scrubs error flags while idle.
module ibex_csr_rmw_ctrl #(
    parameter int          NumCsr  = 4,
    parameter int          Width   = 32,
    parameter bit          ScrubEn = 1'b1,
    localparam int         IdxW    = $clog2(NumCsr)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [1:0]              req_op_i,
    input  logic [IdxW-1:0]         req_sel_i,
    input  logic [Width-1:0]        req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [Width-1:0]        rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic [NumCsr-1:0]       csr_wr_en_o,
    output logic [Width-1:0]        csr_wr_data_o,
    input  logic [NumCsr*Width-1:0] csr_rd_data_i,
    input  logic [NumCsr-1:0]       csr_rd_error_i,
    output logic                    alert_o,
    output logic [IdxW-1:0]         alert_idx_o
);

    localparam logic [1:0] OpRead  = 2'd0;
    localparam logic [1:0] OpWrite = 2'd1;
    localparam logic [1:0] OpSet   = 2'd2;
    localparam logic [1:0] OpClear = 2'd3;

    typedef enum logic [2:0] {StIdle, StRd, StWr, StChk, StRsp} state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q;
    logic [IdxW-1:0]   sel_q;
    logic [IdxW-1:0]   scrub_idx_q;
    logic [IdxW-1:0]   alert_idx_q;
    logic [Width-1:0]  wdata_q;
    logic [Width-1:0]  old_q;
    logic [Width-1:0]  new_q;
    logic [Width-1:0]  new_d;
    logic [Width-1:0]  sel_rdata;
    logic              sel_err;
    logic              sel_bad;
    logic              scrub_err;
    logic              err_q;
    logic              alert_q;
    logic              accept;
    logic              scrub_step;
    logic              scrub_hit;
    logic              access_hit;

    // Mux the selected CSR; an index with no matching CSR is flagged as bad.
    always_comb begin
        sel_rdata = '0;
        sel_err   = 1'b0;
        sel_bad   = 1'b1;
        scrub_err = 1'b0;
        for (int i = 0; i < NumCsr; i++) begin
            if (sel_q == IdxW'(i)) begin
                sel_rdata = csr_rd_data_i[i*Width +: Width];
                sel_err   = csr_rd_error_i[i];
                sel_bad   = 1'b0;
            end
            if (scrub_idx_q == IdxW'(i)) begin
                scrub_err = csr_rd_error_i[i];
            end
        end
    end

    always_comb begin
        case (op_q)
            OpWrite: new_d = wdata_q;
            OpSet:   new_d = sel_rdata | wdata_q;
            OpClear: new_d = sel_rdata & ~wdata_q;
            default: new_d = sel_rdata;
        endcase
    end

    assign req_ready_o = (state_q == StIdle);
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (accept) state_d = StRd;
            StRd: begin
                // Reads, failed reads and zero-operand set/clear skip the write entirely.
                if (op_q == OpRead || sel_err || sel_bad ||
                    (op_q != OpWrite && wdata_q == '0)) begin
                    state_d = StRsp;
                end else begin
                    state_d = StWr;
                end
            end
            StWr:   state_d = StChk;
            StChk:  state_d = StRsp;
            StRsp:  if (rsp_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            op_q    <= OpRead;
            sel_q   <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            new_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= req_op_i;
                sel_q   <= req_sel_i;
                wdata_q <= req_wdata_i;
            end
            if (state_q == StRd) begin
                old_q <= sel_rdata;
                new_q <= new_d;
                err_q <= sel_err | sel_bad;
            end
            // Read back after the write lands to verify the primitive took the value.
            if (state_q == StChk) begin
                err_q <= err_q | (sel_rdata != new_q) | sel_err;
            end
        end
    end

    assign scrub_step = ScrubEn && (state_q == StIdle) && !req_valid_i;
    assign scrub_hit  = scrub_step && scrub_err;
    assign access_hit = ((state_q == StRd) || (state_q == StChk)) && sel_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scrub_idx_q <= '0;
            alert_q     <= 1'b0;
            alert_idx_q <= '0;
        end else begin
            if (scrub_step) begin
                scrub_idx_q <= (scrub_idx_q == IdxW'(NumCsr - 1)) ? '0 : scrub_idx_q + 1'b1;
            end
            if (!alert_q && (access_hit || scrub_hit)) begin
                alert_q     <= 1'b1;
                alert_idx_q <= access_hit ? sel_q : scrub_idx_q;
            end
        end
    end

    always_comb begin
        csr_wr_en_o = '0;
        for (int i = 0; i < NumCsr; i++) begin
            csr_wr_en_o[i] = (state_q == StWr) && (sel_q == IdxW'(i));
        end
    end

    assign csr_wr_data_o = new_q;
    assign rsp_valid_o   = (state_q == StRsp);
    assign rsp_rdata_o   = old_q;
    assign rsp_err_o     = (state_q == StRsp) && err_q;
    assign alert_o       = alert_q;
    assign alert_idx_o   = alert_idx_q;

endmodule

// File: tb/tb_ibex_csr_rmw_ctrl.sv
// Bench for ibex_csr_rmw_ctrl: behavioural CSR bank, response scoreboard and directed steps.
module tb_ibex_csr_rmw_ctrl;

    localparam int          N         = 4;
    localparam int          W         = 32;
    localparam logic [31:0] RESET_VAL = 32'h1234_5678;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'd0;
    logic [1:0]    req_sel = 2'd0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [3:0]    wr_en;
    logic [31:0]   wr_data;
    logic [127:0]  rd_data;
    logic [3:0]    err_force = '0;
    logic          alert;
    logic [1:0]    alert_idx;

    logic [31:0]   bank      [N];
    logic [31:0]   drop_mask [N];
    logic [31:0]   exp_csr   [N];
    rsp_t          sb[$];

    int n_cmp = 0;
    int n_err = 0;

    ibex_csr_rmw_ctrl #(.NumCsr(N), .Width(W), .ScrubEn(1'b1)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_sel_i      (req_sel),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .csr_wr_en_o    (wr_en),
        .csr_wr_data_o  (wr_data),
        .csr_rd_data_i  (rd_data),
        .csr_rd_error_i (err_force),
        .alert_o        (alert),
        .alert_idx_o    (alert_idx)
    );

    always #5 clk = ~clk;

    // Behavioural CSR bank; drop_mask models a primitive that loses written bits.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) bank[i] <= RESET_VAL;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr_en[i]) bank[i] <= wr_data & ~drop_mask[i];
            end
        end
    end

    assign rd_data = {bank[3], bank[2], bank[1], bank[0]};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) exp_csr[i] = RESET_VAL;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic do_req(input logic [1:0] op, input int sel, input logic [31:0] wd,
                          input bit pre_err, input int hold);
        logic [31:0] nv;
        logic [31:0] stored;
        logic [3:0]  pval;
        bit          ww;
        int          lat;
        int          pulses;
        int          pcyc;
        rsp_t        e;
        rsp_t        got;
        case (op)
            2'd1:    nv = wd;
            2'd2:    nv = exp_csr[sel] | wd;
            2'd3:    nv = exp_csr[sel] & ~wd;
            default: nv = exp_csr[sel];
        endcase
        ww      = !pre_err && (op != 2'd0) && !(op[1] && wd == 32'd0);
        stored  = nv & ~drop_mask[sel];
        e.rdata = exp_csr[sel];
        e.err   = pre_err || (ww && stored != nv);
        if (ww) exp_csr[sel] = stored;

        chk("req_ready_idle", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_op    = op;
        req_sel   = sel[1:0];
        req_wdata = wd;
        if (pre_err) err_force[sel] = 1'b1;
        if (hold > 0) rsp_ready = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;

        lat = 1; pulses = 0; pcyc = 0; pval = '0;
        while (!rsp_valid && lat < 20) begin
            if (wr_en != '0) begin
                pulses++;
                pcyc = lat;
                pval = wr_en;
            end
            @(posedge clk); #1;
            lat++;
        end
        chk("rsp_timeout", 64'(rsp_valid), 64'(1));
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 64'(sb.size()), 64'(1));
            end else begin
                got = '{rdata: rsp_rdata, err: rsp_err};
                e   = sb.pop_front();
                chk("rsp_rdata", 64'(got.rdata), 64'(e.rdata));
                chk("rsp_err", 64'(got.err), 64'(e.err));
                chk("latency", 64'(lat), 64'(ww ? 4 : 2));
                chk("wr_pulses", 64'(pulses), 64'(ww ? 1 : 0));
                if (ww) begin
                    chk("wr_cycle", 64'(pcyc), 64'(2));
                    chk("wr_onehot", 64'(pval), 64'(4'b0001 << sel));
                end
                for (int k = 0; k < hold; k++) begin
                    @(posedge clk); #1;
                    chk("hold_valid", 64'(rsp_valid), 64'(1));
                    chk("hold_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    chk("hold_err", 64'(rsp_err), 64'(e.err));
                    chk("hold_req_ready", 64'(req_ready), 64'(0));
                end
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        err_force = '0;
        chk("rsp_done", 64'(rsp_valid), 64'(0));
        chk("csr_contents", 64'(bank[sel]), 64'(exp_csr[sel]));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            drop_mask[i] = '0;
            exp_csr[i]   = RESET_VAL;
        end
        do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst_wr_en", 64'(wr_en), 64'(0));
        chk("rst_wr_data", 64'(wr_data), 64'(0));
        chk("rst_alert", 64'(alert), 64'(0));
        chk("rst_alert_idx", 64'(alert_idx), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_req(2'd1, 1, 32'hDEAD_BEEF, 1'b0, 0);
        do_req(2'd1, 1, 32'h00FF_00FF, 1'b0, 0);
        do_req(2'd2, 1, 32'h0F00_0000, 1'b0, 0);
        do_req(2'd3, 1, 32'h0000_00FF, 1'b0, 0);
        do_req(2'd0, 1, 32'h0000_0000, 1'b0, 0);
        do_req(2'd2, 1, 32'h0000_0000, 1'b0, 0);
        do_req(2'd3, 1, 32'h0000_0000, 1'b0, 0);
        do_req(2'd1, 3, 32'hCAFE_F00D, 1'b0, 0);
        chk("csr1_final", 64'(bank[1]), 64'(32'h0FFF_0000));

        drop_mask[0] = 32'h0000_0001;
        do_req(2'd1, 0, 32'h0000_00FF, 1'b0, 0);
        drop_mask[0] = '0;
        chk("verify_no_alert", 64'(alert), 64'(0));

        do_req(2'd1, 2, 32'h5555_AAAA, 1'b1, 0);
        chk("err_alert", 64'(alert), 64'(1));
        chk("err_alert_idx", 64'(alert_idx), 64'(2));

        do_req(2'd0, 1, 32'h0, 1'b0, 5);

        do_reset();
        chk("scrub_rst_alert", 64'(alert), 64'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        err_force[3] = 1'b1;
        @(posedge clk); #1;
        err_force[3] = 1'b0;
        chk("scrub_wrong_idx", 64'(alert), 64'(0));
        err_force[3] = 1'b1;
        @(posedge clk); #1;
        err_force[3] = 1'b0;
        chk("scrub_alert", 64'(alert), 64'(1));
        chk("scrub_alert_idx", 64'(alert_idx), 64'(3));

        do_reset();
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_sel   = 2'd3;
        req_wdata = 32'hAAAA_5555;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_abort_wr_en", 64'(wr_en), 64'(4'b1000));
        rst_n = 1'b0;
        #1;
        chk("abort_wr_en", 64'(wr_en), 64'(0));
        chk("abort_req_ready", 64'(req_ready), 64'(1));
        chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("abort_wr_data", 64'(wr_data), 64'(0));
        chk("abort_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("abort_alert", 64'(alert), 64'(0));
        for (int i = 0; i < N; i++) exp_csr[i] = RESET_VAL;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_req(2'd0, 3, 32'h0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
